// File: rtl/axis_video_rx_pkg.sv
// Shared types for the video stream receiver: FSM state and error bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_video_pkg;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      LINE     = 1'b1
   } rx_state_e;

   localparam int ERR_W         = 3;
   localparam int ERR_EOL_EARLY = 0;
   localparam int ERR_EOL_LATE  = 1;
   localparam int ERR_SOF_EARLY = 2;

endpackage

// File: rtl/axis_video_rx_if.sv
// AXI4-Stream video link: data, start-of-frame (TUSER), end-of-line (TLAST), valid/ready.
// Latency: none, wires only.
// Backpressure: TREADY driven by the drain side.
interface axis_video_rx_if #(
   parameter int DW = 32
);
   logic [DW-1:0] TDATA;
   logic [3:0]    TKEEP;
   logic          TLAST;
   logic          TUSER;
   logic          TVALID;
   logic          TREADY;

   modport source  (output TDATA, TKEEP, TLAST, TUSER, TVALID, input TREADY);
   modport drain   (input TDATA, TKEEP, TLAST, TUSER, TVALID, output TREADY);
   modport monitor (input TDATA, TKEEP, TLAST, TUSER, TVALID, TREADY);
endinterface

// File: rtl/axis_video_rx_oreg.sv
// Single-entry pixel output register carrying data, x/y and sof/eol/eof tags.
// Latency: one cycle from load to o_vld.
// Backpressure: holds all fields while o_vld & ~i_rdy; o_up_rdy = ~o_vld | i_rdy.
module axis_video_rx_oreg #(
   parameter int DW = 32,
   parameter int CW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [DW-1:0] i_data,
   input  logic [CW-1:0] i_x,
   input  logic [CW-1:0] i_y,
   input  logic          i_sof,
   input  logic          i_eol,
   input  logic          i_eof,
   input  logic          i_rdy,
   output logic          o_vld,
   output logic [DW-1:0] o_data,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_sof,
   output logic          o_eol,
   output logic          o_eof,
   output logic          o_up_rdy
);
   logic          r_vld;
   logic [DW-1:0] r_data;
   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic          r_sof;
   logic          r_eol;
   logic          r_eof;

   // Capture a forwarded pixel, or retire the held one once downstream takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= 1'b0;
         r_data <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_sof  <= 1'b0;
         r_eol  <= 1'b0;
         r_eof  <= 1'b0;
      end else if (i_load) begin
         r_vld  <= 1'b1;
         r_data <= i_data;
         r_x    <= i_x;
         r_y    <= i_y;
         r_sof  <= i_sof;
         r_eol  <= i_eol;
         r_eof  <= i_eof;
      end else if (i_rdy) begin
         r_vld  <= 1'b0;
      end
   end

   assign o_vld    = r_vld;
   assign o_data   = r_data;
   assign o_x      = r_x;
   assign o_y      = r_y;
   assign o_sof    = r_sof;
   assign o_eol    = r_eol;
   assign o_eof    = r_eof;
   assign o_up_rdy = ~r_vld | i_rdy;
endmodule

// File: rtl/axis_video_rx.sv
// Video stream receiver: checks SOF/EOL geometry, tags pixels with x/y, counts frames.
// Latency: one cycle from beat acceptance to pix_valid.
// Backpressure: s_TREADY = ~en | ~pix_valid | pix_ready; held low during reset.
module axis_video_rx
   import axis_video_pkg::*;
#(
   parameter int DW       = 32,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CW       = 12
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   axis_video_rx_if.drain   s,
   input  logic             en,
   input  logic             err_clr,
   output logic [DW-1:0]    pix_data,
   output logic [CW-1:0]    pix_x,
   output logic [CW-1:0]    pix_y,
   output logic             pix_sof,
   output logic             pix_eol,
   output logic             pix_eof,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [ERR_W-1:0] err,
   output logic [15:0]      frame_cnt,
   output logic             busy
);
   localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

   rx_state_e        r_state;
   logic [CW-1:0]    r_x;
   logic [CW-1:0]    r_y;
   logic [ERR_W-1:0] r_err;
   logic [15:0]      r_frame_cnt;

   logic             w_up_rdy;
   logic             w_tready;
   logic             w_acc;
   logic             w_fwd;
   logic             w_eol;
   logic             w_eof;
   logic             w_frame_done;
   logic [CW-1:0]    w_cx;
   logic [CW-1:0]    w_cy;
   logic [CW-1:0]    w_nx;
   logic [CW-1:0]    w_ny;
   rx_state_e        w_next_state;
   logic [ERR_W-1:0] w_err_set;
   logic             w_unused;

   assign w_tready = ARESETn & (~en | w_up_rdy);
   assign s.TREADY = w_tready;
   assign w_acc    = s.TVALID & w_tready;
   assign w_unused = ^s.TKEEP;

   // Classify the accepted beat: a SOF beat restarts at (0,0), then the EOL rules decide forward/drop.
   always_comb begin
      w_fwd        = 1'b0;
      w_eol        = 1'b0;
      w_eof        = 1'b0;
      w_frame_done = 1'b0;
      w_err_set    = '0;
      w_cx         = r_x;
      w_cy         = r_y;
      w_nx         = r_x;
      w_ny         = r_y;
      w_next_state = r_state;
      if (w_acc && en) begin
         if (s.TUSER) begin
            w_cx = '0;
            w_cy = '0;
            if (r_state == LINE) w_err_set[ERR_SOF_EARLY] = 1'b1;
         end
         // In WAIT_SOF only a SOF beat gets past this point; everything else is dropped.
         if (r_state == LINE || s.TUSER) begin
            if (s.TLAST && w_cx != X_LAST) begin
               w_err_set[ERR_EOL_EARLY] = 1'b1;
               w_next_state             = WAIT_SOF;
            end else if (!s.TLAST && w_cx == X_LAST) begin
               w_err_set[ERR_EOL_LATE] = 1'b1;
               w_next_state            = WAIT_SOF;
            end else if (s.TLAST) begin
               w_fwd = 1'b1;
               w_eol = 1'b1;
               w_nx  = '0;
               if (w_cy == Y_LAST) begin
                  w_eof        = 1'b1;
                  w_frame_done = 1'b1;
                  w_ny         = '0;
                  w_next_state = WAIT_SOF;
               end else begin
                  w_ny         = w_cy + CW'(1);
                  w_next_state = LINE;
               end
            end else begin
               w_fwd        = 1'b1;
               w_nx         = w_cx + CW'(1);
               w_ny         = w_cy;
               w_next_state = LINE;
            end
         end
      end
   end

   // Frame FSM with coordinates, sticky errors and frame counter; en low abandons the frame silently.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state     <= WAIT_SOF;
         r_x         <= '0;
         r_y         <= '0;
         r_err       <= '0;
         r_frame_cnt <= '0;
      end else begin
         if (!en) begin
            r_state <= WAIT_SOF;
            r_x     <= '0;
            r_y     <= '0;
         end else begin
            r_state <= w_next_state;
            r_x     <= w_nx;
            r_y     <= w_ny;
         end
         r_err <= err_clr ? '0 : (r_err | w_err_set);
         if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign err       = r_err;
   assign frame_cnt = r_frame_cnt;
   assign busy      = (r_state == LINE);

   axis_video_rx_oreg #(
      .DW (DW),
      .CW (CW)
   ) u_oreg (
      .clk      (ACLK),
      .rst_n    (ARESETn),
      .i_load   (w_fwd),
      .i_data   (s.TDATA),
      .i_x      (w_cx),
      .i_y      (w_cy),
      .i_sof    (s.TUSER),
      .i_eol    (w_eol),
      .i_eof    (w_eof),
      .i_rdy    (pix_ready),
      .o_vld    (pix_valid),
      .o_data   (pix_data),
      .o_x      (pix_x),
      .o_y      (pix_y),
      .o_sof    (pix_sof),
      .o_eol    (pix_eol),
      .o_eof    (pix_eof),
      .o_up_rdy (w_up_rdy)
   );
endmodule

// File: tb/tb_axis_video_rx.sv
// Bench for axis_video_rx with a 4x2 frame: vector table plus backpressure/enable/reset sequences.
// Latency: expects pixels one cycle after acceptance.
// Backpressure: exercises random pix_ready stalls.
module tb_axis_video_rx;
   localparam int DW = 32;
   localparam int H  = 4;
   localparam int V  = 2;
   localparam int CW = 4;

   logic          ACLK = 1'b0;
   logic          ARESETn;
   logic          en;
   logic          err_clr;
   logic [DW-1:0] pix_data;
   logic [CW-1:0] pix_x;
   logic [CW-1:0] pix_y;
   logic          pix_sof;
   logic          pix_eol;
   logic          pix_eof;
   logic          pix_valid;
   logic          pix_ready;
   logic [2:0]    err;
   logic [15:0]   frame_cnt;
   logic          busy;

   always #5 ACLK = ~ACLK;

   axis_video_rx_if #(.DW(DW)) s_if ();

   axis_video_rx #(.DW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .CW(CW)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .s         (s_if),
      .en        (en),
      .err_clr   (err_clr),
      .pix_data  (pix_data),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_sof   (pix_sof),
      .pix_eol   (pix_eol),
      .pix_eof   (pix_eof),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .err       (err),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   typedef struct {
      logic          u;
      logic          l;
      logic          clr;
      logic          fwd;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          sof;
      logic          eol;
      logic          eof;
      logic [2:0]    err;
      logic [15:0]   cnt;
      logic          busy;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [42:0] pix_fields();
      return {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic u, input logic l, input logic clr, input logic fwd,
                      input int x, input int y, input logic sof, input logic eol, input logic eof,
                      input int e, input int cnt, input logic b);
      vec_t v;
      v.u = u; v.l = l; v.clr = clr; v.fwd = fwd;
      v.x = CW'(x); v.y = CW'(y);
      v.sof = sof; v.eol = eol; v.eof = eof;
      v.err = 3'(e); v.cnt = 16'(cnt); v.busy = b;
      vq.push_back(v);
   endtask

   // A complete clean 4x2 frame; first beat optionally pulses err_clr.
   task automatic add_frame(input int e, input int cnt, input logic clr_first);
      for (int i = 0; i < 8; i++)
         add(i == 0, (i % 4) == 3, clr_first && i == 0, 1'b1, i % 4, i / 4,
             i == 0, (i % 4) == 3, i == 7, e, (i == 7) ? cnt + 1 : cnt, i != 7);
   endtask

   task automatic send(input logic u, input logic l, input logic [DW-1:0] d);
      @(negedge ACLK);
      s_if.TVALID = 1'b1;
      s_if.TUSER  = u;
      s_if.TLAST  = l;
      s_if.TDATA  = d;
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      ARESETn     = 1'b0;
      s_if.TVALID = 1'b0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] expd;
      logic [42:0] snap;
      logic [42:0] expf;
      int          idx;
      int          c;
      int          cyc;
      int          i8;
      bit          acc_pend;
      bit          snap_vld;

      ARESETn     = 1'b0;
      en          = 1'b1;
      err_clr     = 1'b0;
      pix_ready   = 1'b1;
      s_if.TVALID = 1'b0;
      s_if.TUSER  = 1'b0;
      s_if.TLAST  = 1'b0;
      s_if.TDATA  = '0;
      s_if.TKEEP  = 4'hF;

      // Reset state
      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_tready", s_if.TREADY, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_fields", pix_fields(), 0);
      chk("rst_err", err, 0);
      chk("rst_cnt", frame_cnt, 0);
      chk("rst_busy", busy, 0);
      @(negedge ACLK);
      ARESETn = 1'b1;

      // Vector table
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      // junk before SOF
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_frame(0, 0, 1'b0);                        // frame 1
      add(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1);      // SOF
      add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);      // early EOL at x=2
      add_frame(0, 1, 1'b1);                        // err_clr on first beat, frame 2
      add(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 1);
      add(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);      // late EOL at x=3
      add(1, 0, 0, 1, 0, 0, 1, 0, 0, 2, 2, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 1);
      add_frame(6, 2, 1'b0);                        // mid-line SOF restarts, frame 3
      add(1, 0, 0, 1, 0, 0, 1, 0, 0, 6, 3, 1);
      add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0);      // early EOL lost to err_clr
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);      // SOF+TLAST dropped
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);      // still in WAIT_SOF

      for (int k = 0; k < vq.size(); k++) begin
         @(negedge ACLK);
         s_if.TVALID = 1'b1;
         s_if.TUSER  = vq[k].u;
         s_if.TLAST  = vq[k].l;
         s_if.TDATA  = 32'h1000 + k;
         err_clr     = vq[k].clr;
         @(posedge ACLK);
         #1;
         expd = 32'h1000 + k;
         chk($sformatf("v%0d_valid", k), pix_valid, vq[k].fwd);
         if (vq[k].fwd)
            chk($sformatf("v%0d_pix", k), pix_fields(),
                {expd, vq[k].x, vq[k].y, vq[k].sof, vq[k].eol, vq[k].eof});
         chk($sformatf("v%0d_err", k), err, vq[k].err);
         chk($sformatf("v%0d_cnt", k), frame_cnt, vq[k].cnt);
         chk($sformatf("v%0d_busy", k), busy, vq[k].busy);
      end
      @(negedge ACLK);
      s_if.TVALID = 1'b0;
      err_clr     = 1'b0;
      @(posedge ACLK);
      #1;
      chk("idle_valid", pix_valid, 0);

      // Random backpressure over 3 frames
      do_reset();
      idx = 0; c = 0; cyc = 0; acc_pend = 0; snap_vld = 0; snap = '0;
      while (c < 24 && cyc < 3000) begin
         @(negedge ACLK);
         cyc++;
         if (snap_vld) begin
            chk("bp_hold_valid", pix_valid, 1);
            chk("bp_hold_fields", pix_fields(), snap);
         end
         if (acc_pend) idx++;
         if (idx < 24) begin
            s_if.TVALID = 1'b1;
            s_if.TDATA  = 32'h2000 + idx;
            s_if.TUSER  = (idx % 8) == 0;
            s_if.TLAST  = (idx % 4) == 3;
         end else begin
            s_if.TVALID = 1'b0;
         end
         pix_ready = 1'($urandom_range(0, 1));
         #1;
         acc_pend = s_if.TVALID && s_if.TREADY;
         snap_vld = pix_valid && !pix_ready;
         snap     = pix_fields();
         if (pix_valid && pix_ready) begin
            i8   = c % 8;
            expd = 32'h2000 + c;
            expf = {expd, CW'(i8 % 4), CW'(i8 / 4), i8 == 0, (i8 % 4) == 3, i8 == 7};
            chk($sformatf("bp_pix%0d", c), pix_fields(), expf);
            c++;
         end
      end
      if (c < 24) chk("bp_timeout_pixels", c, 24);
      @(negedge ACLK);
      s_if.TVALID = 1'b0;
      pix_ready   = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      chk("bp_end_valid", pix_valid, 0);
      chk("bp_cnt", frame_cnt, 3);
      chk("bp_err", err, 0);

      // Enable dropped mid-frame with a held pixel
      do_reset();
      pix_ready = 1'b1;
      send(1, 0, 32'hA0);
      send(0, 0, 32'hA1);
      @(negedge ACLK);
      pix_ready   = 1'b0;
      en          = 1'b0;
      s_if.TVALID = 1'b1;
      s_if.TUSER  = 1'b0;
      s_if.TLAST  = 1'b0;
      s_if.TDATA  = 32'hDEAD;
      #1;
      chk("en_tready", s_if.TREADY, 1);
      @(posedge ACLK);
      #1;
      chk("en_hold_valid", pix_valid, 1);
      chk("en_hold_pix", {pix_data, pix_x}, {32'hA1, CW'(1)});
      chk("en_busy", busy, 0);
      chk("en_err", err, 0);
      @(negedge ACLK);
      s_if.TVALID = 1'b0;
      pix_ready   = 1'b1;
      en          = 1'b1;
      @(posedge ACLK);
      #1;
      chk("en_drain_valid", pix_valid, 0);
      send(0, 0, 32'hB0);
      chk("en_abandon_valid", pix_valid, 0);
      for (int i = 0; i < 8; i++) send(i == 0, (i % 4) == 3, 32'hC0 + i);
      chk("en_frame_eof", {pix_valid, pix_eof, pix_data}, {1'b1, 1'b1, 32'hC7});
      chk("en_frame_cnt", frame_cnt, 1);
      chk("en_frame_err", err, 0);

      // Asynchronous reset mid-frame
      send(1, 0, 32'hD0);
      send(0, 1, 32'hD1);
      chk("pre_rst_err", err, 1);
      send(1, 0, 32'hD2);
      send(0, 0, 32'hD3);
      chk("pre_rst_busy", busy, 1);
      @(negedge ACLK);
      #2;
      ARESETn = 1'b0;
      #1;
      chk("arst_tready", s_if.TREADY, 0);
      chk("arst_valid", pix_valid, 0);
      chk("arst_fields", pix_fields(), 0);
      chk("arst_err", err, 0);
      chk("arst_cnt", frame_cnt, 0);
      chk("arst_busy", busy, 0);
      s_if.TVALID = 1'b0;
      repeat (2) @(posedge ACLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_video_rx.md
# axis_video_rx

Drain-side AXI4-Stream video receiver. Consumes a video stream (TUSER[0] = start of frame, TLAST = end of line) and checks frame geometry against the configured active size. It re-emits each accepted pixel on a registered, backpressured pixel port tagged with x/y coordinates. It sits between a video source (VDMA or camera front end) and pixel-processing logic, and reports sticky protocol errors plus a frame counter to the control registers.

## Interface
- DW, 32: TDATA / pixel data width
- H_ACTIVE, 640: pixels per line, must be ≥ 2
- V_ACTIVE, 480: lines per frame, must be ≥ 1
- CW, 12: x/y coordinate width, requires 2^CW ≥ max(H_ACTIVE, V_ACTIVE)
- ACLK  in  1  clock
- ARESETn  in  1  one clock; reset is asynchronous and active-low
- s_TDATA  in  DW  stream data
- s_TKEEP  in  4  ignored
- s_TLAST  in  1  end of line
- s_TUSER  in  1  start of frame
- s_TVALID  in  1  stream valid
- s_TREADY  out  1  stream ready
- en  in  1  receive enable
- err_clr  in  1  single-cycle pulse, clears sticky errors
- pix_data  out  DW  pixel
- pix_x  out  CW  column, 0..H_ACTIVE-1
- pix_y  out  CW  row, 0..V_ACTIVE-1
- pix_sof  out  1  first pixel of frame
- pix_eol  out  1  last pixel of line
- pix_eof  out  1  last pixel of frame
- pix_valid  out  1  pixel valid
- pix_ready  in  1  downstream ready
- err  out  3  sticky errors: [0] early EOL, [1] late EOL, [2] early SOF
- frame_cnt  out  16  complete frames received, wraps
- busy  out  1  state is LINE

## Operation
- A beat is accepted when s_TVALID & s_TREADY.
- s_TREADY = ~en | ~pix_valid | pix_ready. It is 0 while ARESETn is low.
- en = 0: every beat is accepted and dropped. State is forced to WAIT_SOF without setting an error, so a frame is abandoned immediately.
- WAIT_SOF:
  - Accepted beats with TUSER = 0 are dropped silently.
  - A beat with TUSER = 1 is forwarded with x = 0, y = 0, pix_sof = 1, and the state moves to LINE.
- LINE, per accepted beat, in priority order:
  - TUSER = 1: set err[2] and restart the frame at this beat (x = 0, y = 0, pix_sof = 1). It remains in LINE.
  - TLAST = 1 with x < H_ACTIVE-1: set err[0], drop the beat, go to WAIT_SOF.
  - TLAST = 0 with x = H_ACTIVE-1: set err[1], drop the beat, go to WAIT_SOF.
  - TLAST = 1 with x = H_ACTIVE-1: forward with pix_eol = 1.
    - If y = V_ACTIVE-1: also pix_eof = 1, increment frame_cnt, go to WAIT_SOF.
    - Otherwise: x ← 0, y ← y+1.
  - Otherwise: forward, x ← x+1.
- Within one beat, a TUSER = 1 check in WAIT_SOF and an EOL check both apply. If that SOF beat also has TLAST = 1, the early-EOL rule drops it and returns to WAIT_SOF (H_ACTIVE ≥ 2).
- err_clr takes priority over a set in the same cycle: the bits read 0 the next cycle and new errors are lost for that cycle.
- frame_cnt wraps from 0xFFFF to 0.

## Timing
- Reset values: s_TREADY 0, pix_valid 0, pix_data/x/y 0, pix_sof/eol/eof 0, err 0, frame_cnt 0, busy 0, state WAIT_SOF.
- Latency: one cycle from beat acceptance to pix_valid = 1 with its data and tags.
- The pixel port holds all fields stable while pix_valid & ~pix_ready. Full throughput is one pixel per cycle with pix_ready held at 1.
- pix_valid clears the cycle after (pix_valid & pix_ready) unless a new beat is accepted in that cycle.
- A dropped beat never asserts pix_valid.
- err and frame_cnt update on the cycle after the triggering beat is accepted.
- When en falls while pix_valid = 1, the held pixel is still delivered.
- Asynchronous reset mid-frame clears everything immediately, with no partial frame count.

## Structure
- Package axis_video_pkg holds:
  - state enum rx_state_e {WAIT_SOF, LINE}
  - error bit indices ERR_EOL_EARLY = 0, ERR_EOL_LATE = 1, ERR_SOF_EARLY = 2
- The stream port is the interface's drain modport; the parent's monitor modport may observe it.
- One sub-module, axis_video_rx_oreg: a single-entry pixel output register with valid/ready. It holds data, x, y and the sof/eol/eof tags, and provides the upstream-ready term.

## Test plan
- H=4, V=2: clean frame of 8 beats, TUSER on beat 0, TLAST on beats 3 and 7, pix_ready = 1.
  - Response: 8 pixels, x = 0,1,2,3,0,1,2,3 and y = 0,0,0,0,1,1,1,1; eol on 3 and 7, eof on 7; frame_cnt = 1; err = 0.
- Two beats before SOF, then a clean frame.
  - Response: the first two beats are dropped; 8 pixels are forwarded; err = 0.
- TLAST on x = 2 of line 0.
  - Response: err = 3'b001; 2 pixels are forwarded; WAIT_SOF; a following clean frame gives frame_cnt = 1.
- No TLAST at x = 3, then TUSER mid-line in the next frame.
  - Response: err[1] is set after the late EOL; err[2] is set at the mid-line SOF, with pix_sof, x = 0, y = 0 on that beat.
- pix_ready toggled randomly (50%) over 3 frames.
  - Response: no pixel is lost or duplicated; fields stay stable while stalled; frame_cnt = 3.
- en dropped at mid-frame, err_clr pulsed, reset asserted mid-frame.
  - Response: the frame is abandoned with no error and s_TREADY = 1 while en = 0; err reads 0 after err_clr; all outputs go to their reset values immediately.
